sample_stream_bridge: RTL and testbench

Downstream stage of the sine test generator: decimates the free-running 24-bit sine sample stream to one sample every DIV clocks and buffers the captured samples in a small FIFO. The FIFO presents them to the symmetric FIR pipeline input over a valid/ready handshake. It also flags samples lost to FIR back-pressure, so benches can tell a stalled filter from a bad response.

---
 rtl/sample_stream_bridge.sv | 113 +++++++++++
 tb/tb_sample_stream_bridge.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_stream_bridge.sv
// Decimates the sine sample stream to one capture every DIV enabled clocks and buffers it in a FWFT FIFO for the FIR.
// Define OVF_COUNT_EN to add the 16-bit saturating ovf_count port alongside the sticky overflow flag.
module sample_stream_bridge #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 8,
  parameter int DIV    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr_ovf,
  input  logic [DATA_W-1:0]        sample_in,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sample_tick,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
`ifdef OVF_COUNT_EN
  ,
  output logic [15:0]              ovf_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  logic [CW-1:0]     cnt;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic attempt;
  logic full;
  logic rd;
  logic wr;
  logic drop;

  // Handshake: a sample transfers on every rising edge where out_valid and out_ready are both high;
  // out_valid depends only on occupancy and out_data holds steady until that transfer happens.
  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];
  assign full      = (level == LEVEL_FULL);
  assign attempt   = en && (cnt == CNT_LAST);
  assign rd        = out_valid && out_ready;
  assign wr        = attempt && (!full || rd);
  assign drop      = attempt && full && !rd;

  // Dropping en clears the divider so the next enable always waits a full DIV period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr) begin
      mem[wr_ptr] <= sample_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= attempt;
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // A drop on the same edge as clr_ovf still counts, so the flag never hides a fresh loss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

`ifdef OVF_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (drop) begin
      if (clr_ovf)                    ovf_count <= 16'd1;
      else if (ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
    end else if (clr_ovf) begin
      ovf_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_sample_stream_bridge.sv
// Bench for sample_stream_bridge: two instances (DIV=4 and DIV=1) share one directed stimulus stream
// and are checked each cycle against a queue-based model plus literal expectations.
module tb_sample_stream_bridge;

  localparam int DW    = 24;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          clr_ovf;
  logic          out_ready;
  logic [DW-1:0] sample_in;

  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : u
      localparam int D = (g == 0) ? 4 : 1;
      logic [DW-1:0] out_data;
      logic          out_valid;
      logic          sample_tick;
      logic [3:0]    level;
      logic          overflow;
`ifdef OVF_COUNT_EN
      logic [15:0]   ovf_count;
`endif

      sample_stream_bridge #(.DATA_W(DW), .DEPTH(DEPTH), .DIV(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .clr_ovf     (clr_ovf),
        .sample_in   (sample_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sample_tick (sample_tick),
        .level       (level),
        .overflow    (overflow)
`ifdef OVF_COUNT_EN
        ,
        .ovf_count   (ovf_count)
`endif
      );

      // Model: a plain queue of captured samples plus a count of consecutive enabled cycles.
      logic [DW-1:0] mq[$];
      int            run = 0;
      int            exp_size = 0;
      logic [DW-1:0] exp_head = '0;
      bit            exp_tick = 0;
      bit            exp_ovf = 0;
      int            exp_cnt = 0;

      initial begin
        forever begin
          @(posedge clk or negedge rst_n);
          if (!rst_n) begin
            mq.delete();
            run      = 0;
            exp_tick = 0;
            exp_ovf  = 0;
            exp_cnt  = 0;
          end else begin
            bit attempt;
            bit pop;
            bit drop;
            attempt = 0;
            if (en) begin
              run = run + 1;
              if (run == D) begin
                attempt = 1;
                run = 0;
              end
            end else begin
              run = 0;
            end
            pop  = (mq.size() != 0) && out_ready;
            drop = attempt && (mq.size() == DEPTH) && !pop;
            if (pop) void'(mq.pop_front());
            if (attempt && !drop) mq.push_back(sample_in);
            if (drop) begin
              exp_ovf = 1;
              exp_cnt = clr_ovf ? 1 : ((exp_cnt == 65535) ? 65535 : exp_cnt + 1);
            end else if (clr_ovf) begin
              exp_ovf = 0;
              exp_cnt = 0;
            end
            exp_tick = attempt;
          end
          exp_size = mq.size();
          exp_head = (mq.size() != 0) ? mq[0] : '0;
        end
      end
    end
  endgenerate

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string tag, input logic v, input logic [DW-1:0] d,
                          input logic [3:0] lv, input logic t, input logic o,
                          input int esize, input logic [DW-1:0] ehead,
                          input bit etick, input bit eovf);
    chk({tag, ".out_valid"}, 32'(v), 32'(esize != 0));
    if (esize != 0) chk({tag, ".out_data"}, 32'(d), 32'(ehead));
    chk({tag, ".level"}, 32'(lv), 32'(esize));
    chk({tag, ".sample_tick"}, 32'(t), 32'(etick));
    chk({tag, ".overflow"}, 32'(o), 32'(eovf));
  endtask

  always @(negedge clk) begin
    cmp_inst("div4", u[0].out_valid, u[0].out_data, u[0].level, u[0].sample_tick, u[0].overflow,
             u[0].exp_size, u[0].exp_head, u[0].exp_tick, u[0].exp_ovf);
    cmp_inst("div1", u[1].out_valid, u[1].out_data, u[1].level, u[1].sample_tick, u[1].overflow,
             u[1].exp_size, u[1].exp_head, u[1].exp_tick, u[1].exp_ovf);
`ifdef OVF_COUNT_EN
    chk("div4.ovf_count", 32'(u[0].ovf_count), 32'(u[0].exp_cnt));
    chk("div1.ovf_count", 32'(u[1].ovf_count), 32'(u[1].exp_cnt));
`endif
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [DW-1:0] drain_exp [8];

  initial begin
    rst_n     = 1'b1;
    en        = 1'b0;
    clr_ovf   = 1'b0;
    out_ready = 1'b1;
    sample_in = '0;
    #1 rst_n  = 1'b0;
    repeat (3) step();

    // Reset values, memory included.
    chk("rst_out_valid", 32'(u[0].out_valid), 0);
    chk("rst_out_data", 32'(u[0].out_data), 0);
    chk("rst_level", 32'(u[0].level), 0);
    chk("rst_overflow", 32'(u[1].overflow), 0);
    chk("rst_tick", 32'(u[1].sample_tick), 0);
    rst_n = 1'b1;
    step();

    // Ramp with out_ready=1: DIV=4 delivers 3, 7, 11 ...
    en = 1'b1;
    sample_in = '0;
    for (int k = 1; k <= 20; k++) begin
      step();
      sample_in = DW'(k);
      if (k == 3) chk("ramp_not_yet_valid", 32'(u[0].out_valid), 0);
      if (k == 4) begin
        chk("ramp_first_valid", 32'(u[0].out_valid), 1);
        chk("ramp_first_data", 32'(u[0].out_data), 3);
      end
      if (k == 8)  chk("ramp_second_data", 32'(u[0].out_data), 7);
      if (k == 12) chk("ramp_third_data", 32'(u[0].out_data), 11);
      chk("ramp_div4_level_le1", 32'(u[0].level > 4'd1), 0);
      chk("ramp_div1_level_le1", 32'(u[1].level > 4'd1), 0);
    end
    chk("ramp_no_overflow", 32'(u[0].overflow | u[1].overflow), 0);
    en = 1'b0;
    repeat (3) step();

    // Fill DIV=1 instance with out_ready=0: 10 attempts, 2 dropped.
    out_ready = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      sample_in = DW'(100 + k);
      step();
    end
    chk("fill_level_full", 32'(u[1].level), 8);
    chk("fill_overflow", 32'(u[1].overflow), 1);
`ifdef OVF_COUNT_EN
    chk("fill_ovf_count", 32'(u[1].ovf_count), 2);
`endif

    // Capture and pop on the same edge while full: no drop, oldest leaves.
    sample_in = DW'(110);
    out_ready = 1'b1;
    step();
    chk("fullrw_level", 32'(u[1].level), 8);
    chk("fullrw_head", 32'(u[1].out_data), 101);
`ifdef OVF_COUNT_EN
    chk("fullrw_ovf_count", 32'(u[1].ovf_count), 2);
`endif
    en = 1'b0;
    drain_exp = '{DW'(101), DW'(102), DW'(103), DW'(104), DW'(105), DW'(106), DW'(107), DW'(110)};
    for (int j = 0; j < 8; j++) begin
      chk("drain_valid", 32'(u[1].out_valid), 1);
      chk("drain_data", 32'(u[1].out_data), 32'(drain_exp[j]));
      step();
    end
    chk("drain_empty", 32'(u[1].out_valid), 0);

    // Clear, refill, then drop on the same edge as clr_ovf.
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_overflow", 32'(u[1].overflow), 0);
    out_ready = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sample_in = DW'(200 + k);
      step();
    end
    chk("refill_level", 32'(u[1].level), 8);
    chk("refill_no_overflow", 32'(u[1].overflow), 0);
    sample_in = DW'(208);
    clr_ovf = 1'b1;
    step();
    chk("clr_vs_drop_overflow", 32'(u[1].overflow), 1);
`ifdef OVF_COUNT_EN
    chk("clr_vs_drop_count", 32'(u[1].ovf_count), 1);
`endif
    en = 1'b0;
    step();
    clr_ovf = 1'b0;
    chk("clr_only_overflow", 32'(u[1].overflow), 0);

    // en dropped at cnt=2 restarts a full period.
    out_ready = 1'b1;
    repeat (9) step();
    en = 1'b1;
    repeat (2) step();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("en_low_no_tick", 32'(u[0].sample_tick), 0);
    end
    en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("tick_spacing", 32'(u[0].sample_tick), 32'(k == 4 || k == 8));
    end
    en = 1'b0;
    repeat (3) step();

    // Reset mid-stream with five samples buffered.
    out_ready = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      sample_in = DW'(300 + k);
      step();
    end
    chk("pre_reset_level", 32'(u[0].level), 5);
    chk("pre_reset_head", 32'(u[0].out_data), 303);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(u[0].out_valid), 0);
    chk("async_rst_level", 32'(u[0].level), 0);
    chk("async_rst_div1_level", 32'(u[1].level), 0);
    chk("async_rst_overflow", 32'(u[1].overflow), 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      sample_in = DW'(400 + k - 1);
      step();
      if (k < 4) begin
        chk("post_rst_no_stale", 32'(u[0].out_valid), 0);
      end else begin
        chk("post_rst_first_valid", 32'(u[0].out_valid), 1);
        chk("post_rst_first_data", 32'(u[0].out_data), 403);
      end
    end
    en = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
